// File: rtl/prog_loader_if.sv
// Program-load bus between the serial loader and the UltraTiny CPU.
// It carries the UART line into the loader, and the memory-write and run-control signals out of it.
interface prog_loader_if;
  logic       rx;
  logic       load_mode;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       cpu_run;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  rx,
    output load_mode, load_addr, load_data, cpu_run, busy, done, err
  );

  modport slave (
    output rx,
    input  load_mode, load_addr, load_data, cpu_run, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader for the UltraTiny CPU.
// It receives a framed image over 8N1 UART (sync, count, data bytes, checksum) and writes each data
// byte into CPU memory. It holds the CPU until a frame with a matching checksum has been loaded.
module prog_loader #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {F_IDLE, F_COUNT, F_DATA, F_CHECK} frame_state_t;

  logic rx_meta, rx_sync, rx_prev;

  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          byte_valid, byte_valid_n;
  logic          frame_err, frame_err_n;

  frame_state_t f_state, f_state_n;
  logic [4:0]   f_count, f_count_n;
  logic [4:0]   f_idx, f_idx_n;
  logic [7:0]   f_sum, f_sum_n;
  logic         lm_q, lm_n;
  logic [3:0]   la_q, la_n;
  logic [7:0]   ld_q, ld_n;
  logic         run_q, run_n;
  logic         busy_q, busy_n;
  logic         done_q, done_n;
  logic         err_q, err_n;

  // Two-flop synchroniser on rx, plus a delayed copy for falling-edge detection.
  // The flops reset to 0, so a line held low across reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Byte engine state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= R_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      bit_cnt    <= bit_cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  // Byte engine next state. It re-checks the start bit at half a bit time, shifts data bits in LSB first,
  // and pulses byte_valid or frame_err once the stop bit has been sampled.
  always_comb begin
    rx_state_n   = rx_state;
    bit_cnt_n    = bit_cnt;
    bit_idx_n    = bit_idx;
    shift_n      = shift;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_n = R_START;
          bit_cnt_n  = '0;
        end
      end
      R_START: begin
        if (bit_cnt == CNT_HALF) begin
          bit_cnt_n = '0;
          if (!rx_sync) begin
            rx_state_n = R_DATA;
            bit_idx_n  = '0;
          end else begin
            rx_state_n = R_IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      R_DATA: begin
        if (bit_cnt == CNT_FULL) begin
          bit_cnt_n = '0;
          shift_n   = {rx_sync, shift[7:1]};
          if (bit_idx == 3'd7) begin
            rx_state_n = R_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      R_STOP: begin
        if (bit_cnt == CNT_FULL) begin
          bit_cnt_n  = '0;
          rx_state_n = R_IDLE;
          if (rx_sync) begin
            byte_valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  // Frame state register and the registered CPU-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_state <= F_IDLE;
      f_count <= '0;
      f_idx   <= '0;
      f_sum   <= '0;
      lm_q    <= 1'b0;
      la_q    <= '0;
      ld_q    <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      f_state <= f_state_n;
      f_count <= f_count_n;
      f_idx   <= f_idx_n;
      f_sum   <= f_sum_n;
      lm_q    <= lm_n;
      la_q    <= la_n;
      ld_q    <= ld_n;
      run_q   <= run_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Frame parser. A framing error inside a frame aborts it, drops busy and the write strobe, and flags err.
  // Outside a frame, framing errors and non-sync bytes are ignored.
  always_comb begin
    f_state_n = f_state;
    f_count_n = f_count;
    f_idx_n   = f_idx;
    f_sum_n   = f_sum;
    lm_n      = lm_q;
    la_n      = la_q;
    ld_n      = ld_q;
    run_n     = run_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    err_n     = err_q;
    if (frame_err && f_state != F_IDLE) begin
      f_state_n = F_IDLE;
      err_n     = 1'b1;
      busy_n    = 1'b0;
      lm_n      = 1'b0;
    end else if (byte_valid) begin
      case (f_state)
        F_IDLE: begin
          if (shift == SYNC_BYTE) begin
            f_state_n = F_COUNT;
            busy_n    = 1'b1;
            err_n     = 1'b0;
            run_n     = 1'b0;
          end
        end
        F_COUNT: begin
          if (shift != 8'd0 && shift <= 8'd16) begin
            f_count_n = shift[4:0];
            f_idx_n   = '0;
            f_sum_n   = '0;
            f_state_n = F_DATA;
          end else begin
            err_n     = 1'b1;
            busy_n    = 1'b0;
            f_state_n = F_IDLE;
          end
        end
        F_DATA: begin
          la_n    = f_idx[3:0];
          ld_n    = shift;
          lm_n    = 1'b1;
          f_sum_n = f_sum + shift;
          f_idx_n = f_idx + 5'd1;
          if (f_idx == f_count - 5'd1) begin
            f_state_n = F_CHECK;
          end
        end
        F_CHECK: begin
          lm_n      = 1'b0;
          busy_n    = 1'b0;
          f_state_n = F_IDLE;
          if (shift == f_sum) begin
            done_n = 1'b1;
            run_n  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        default: f_state_n = F_IDLE;
      endcase
    end
  end

  assign bus.load_mode = lm_q;
  assign bus.load_addr = la_q;
  assign bus.load_data = ld_q;
  assign bus.cpu_run   = run_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader. A byte-level frame model predicts the registered outputs, and a
// per-cycle compare process checks the DUT against it. Directed frames pin the model with literal values;
// random frames exercise noise, bad counts, bad checksums, framing errors and back-to-back bytes.
module tb_prog_loader;

  localparam int C   = 4;
  localparam int LAT = (19 * C) / 2 + 4;

  typedef struct {
    int         apply;
    logic       lm;
    logic [3:0] a;
    logic [7:0] d;
    logic       run;
    logic       busy;
    logic       err;
    logic       done;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  prog_loader_if bus ();

  prog_loader #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Cycle counter; all model timestamps are taken from it.
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  ev_t         evq[$];
  ev_t         cur;
  ev_t         m_out;
  int          m_phase = 0;
  int          m_n = 0;
  int          m_idx = 0;
  logic [7:0]  m_sum = 8'd0;
  int          last_apply = -100;
  int          exp_done_total = 0;
  int          dut_done_total = 0;
  logic [11:0] exp_wr[$];
  logic [11:0] obs_wr[$];
  logic [11:0] lit_wr[$];
  logic [7:0]  tx_q[$];
  logic        prev_done = 1'b0;
  logic        prev_run = 1'b0;
  logic        prev_lm = 1'b0;
  logic [3:0]  prev_a = 4'd0;
  logic [7:0]  prev_d = 8'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame rules applied to one received byte; the resulting outputs take effect one byte latency later.
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok, input int start_cyc);
    m_out.done = 1'b0;
    if (!stop_ok) begin
      if (m_phase != 0) begin
        m_out.err  = 1'b1;
        m_out.busy = 1'b0;
        m_out.lm   = 1'b0;
        m_phase    = 0;
      end
    end else begin
      case (m_phase)
        0: if (b == 8'hA5) begin
             m_phase     = 1;
             m_out.busy  = 1'b1;
             m_out.err   = 1'b0;
             m_out.run   = 1'b0;
           end
        1: if (b >= 8'd1 && b <= 8'd16) begin
             m_n     = int'(b);
             m_idx   = 0;
             m_sum   = 8'd0;
             m_phase = 2;
           end else begin
             m_out.err  = 1'b1;
             m_out.busy = 1'b0;
             m_phase    = 0;
           end
        2: begin
             m_out.lm = 1'b1;
             m_out.a  = m_idx[3:0];
             m_out.d  = b;
             exp_wr.push_back({m_idx[3:0], b});
             m_sum = m_sum + b;
             m_idx++;
             if (m_idx == m_n) m_phase = 3;
           end
        default: begin
             m_out.lm   = 1'b0;
             m_out.busy = 1'b0;
             if (b == m_sum) begin
               m_out.done = 1'b1;
               m_out.run  = 1'b1;
             end else begin
               m_out.err = 1'b1;
             end
             m_phase = 0;
           end
      endcase
    end
    m_out.apply = start_cyc + LAT;
    evq.push_back(m_out);
  endfunction

  function automatic void model_reset();
    ev_t z;
    z = '{apply: 0, lm: 1'b0, a: 4'd0, d: 8'd0, run: 1'b0, busy: 1'b0, err: 1'b0, done: 1'b0};
    evq.delete();
    cur     = z;
    m_out   = z;
    m_phase = 0;
    exp_wr.delete();
    obs_wr.delete();
    last_apply = cyc;
  endfunction

  // Per-cycle compare. Cycles within two clocks of a predicted output update are skipped for level
  // checks, but done pulses and writes are tracked on every cycle.
  always @(negedge clk) begin
    bit quiet;
    while (evq.size() > 0 && evq[0].apply <= cyc) begin
      cur = evq.pop_front();
      exp_done_total += int'(cur.done);
      last_apply = cur.apply;
    end
    if (bus.done === 1'b1) begin
      dut_done_total++;
      checkOutput("done_width", {31'd0, prev_done}, 32'd0);
      checkOutput("done_run_edge", {30'd0, prev_run, bus.cpu_run}, 32'd1);
    end
    if (bus.load_mode === 1'b1 &&
        (!prev_lm || bus.load_addr !== prev_a || bus.load_data !== prev_d))
      obs_wr.push_back({bus.load_addr, bus.load_data});
    quiet = (rst === 1'b0) && (cyc - last_apply > 2) &&
            !(evq.size() > 0 && evq[0].apply - cyc <= 2);
    if (quiet) begin
      checkOutput("load_mode", {31'd0, bus.load_mode}, {31'd0, cur.lm});
      checkOutput("load_addr", {28'd0, bus.load_addr}, {28'd0, cur.a});
      checkOutput("load_data", {24'd0, bus.load_data}, {24'd0, cur.d});
      checkOutput("cpu_run", {31'd0, bus.cpu_run}, {31'd0, cur.run});
      checkOutput("busy", {31'd0, bus.busy}, {31'd0, cur.busy});
      checkOutput("err", {31'd0, bus.err}, {31'd0, cur.err});
      checkOutput("done_count", dut_done_total, exp_done_total);
    end
    prev_done = bus.done;
    prev_run  = bus.cpu_run;
    prev_lm   = bus.load_mode;
    prev_a    = bus.load_addr;
    prev_d    = bus.load_data;
  end

  // Sends one UART byte starting on a falling clock edge, then idles for gap cycles.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input int gap);
    int g;
    model_byte(b, stop_ok, cyc);
    bus.rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (C) @(negedge clk);
    end
    bus.rx = stop_ok;
    repeat (C) @(negedge clk);
    bus.rx = 1'b1;
    g = gap;
    if (!stop_ok && g < 2 * C) g = 2 * C;
    repeat (g) @(negedge clk);
  endtask

  task automatic send_frame(input int gap);
    foreach (tx_q[i]) applyStimulus(tx_q[i], 1'b1, gap);
    tx_q.delete();
    repeat (LAT + 10) @(negedge clk);
  endtask

  // Compares the writes seen on the bus against the model's writes for the frame just sent.
  task automatic check_writes(input string name);
    checkOutput({name, "_count"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      checkOutput({name, "_pair"}, {20'd0, obs_wr[i]}, {20'd0, exp_wr[i]});
    obs_wr.delete();
    exp_wr.delete();
  endtask

  // Pins the model's predicted writes to hand-computed literal pairs.
  task automatic pin_writes(input string name);
    checkOutput({name, "_model_count"}, exp_wr.size(), lit_wr.size());
    for (int i = 0; i < lit_wr.size() && i < exp_wr.size(); i++)
      checkOutput({name, "_model_pair"}, {20'd0, exp_wr[i]}, {20'd0, lit_wr[i]});
    lit_wr.delete();
  endtask

  initial begin
    int d0;
    int n;
    int kind;
    int fe_at;
    int gap;
    logic [7:0] b;
    logic [7:0] sum;

    rst    = 1'b1;
    bus.rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {16'd0, bus.load_mode, bus.load_addr, bus.load_data, bus.cpu_run, bus.busy, bus.done, bus.err},
                32'd0);
    rst = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);

    $display("[TB] good frame");
    d0 = dut_done_total;
    tx_q = '{8'hA5, 8'h03, 8'h12, 8'h20, 8'hB0, 8'hE2};
    send_frame(0);
    lit_wr = '{12'h012, 12'h120, 12'h2B0};
    pin_writes("good");
    check_writes("good_writes");
    checkOutput("good_run", {31'd0, bus.cpu_run}, 32'd1);
    checkOutput("good_err", {31'd0, bus.err}, 32'd0);
    checkOutput("good_done_pulses", dut_done_total - d0, 32'd1);

    $display("[TB] bad checksum");
    d0 = dut_done_total;
    tx_q = '{8'hA5, 8'h03, 8'h12, 8'h20, 8'hB0, 8'hE3};
    send_frame(2);
    lit_wr = '{12'h012, 12'h120, 12'h2B0};
    pin_writes("badsum");
    check_writes("badsum_writes");
    checkOutput("badsum_err", {31'd0, bus.err}, 32'd1);
    checkOutput("badsum_run", {31'd0, bus.cpu_run}, 32'd0);
    checkOutput("badsum_done_pulses", dut_done_total - d0, 32'd0);

    $display("[TB] bad count");
    tx_q = '{8'hA5, 8'h00};
    send_frame(0);
    checkOutput("cnt0_err", {31'd0, bus.err}, 32'd1);
    checkOutput("cnt0_busy", {31'd0, bus.busy}, 32'd0);
    check_writes("cnt0_writes");
    tx_q = '{8'hA5, 8'h11};
    send_frame(0);
    checkOutput("cnt17_err", {31'd0, bus.err}, 32'd1);
    checkOutput("cnt17_busy", {31'd0, bus.busy}, 32'd0);
    check_writes("cnt17_writes");

    $display("[TB] noise before sync");
    d0 = dut_done_total;
    tx_q = '{8'h3C, 8'hFF, 8'hA5, 8'h01, 8'h7F, 8'h7F};
    send_frame(1);
    lit_wr = '{12'h07F};
    pin_writes("noise");
    check_writes("noise_writes");
    checkOutput("noise_done_pulses", dut_done_total - d0, 32'd1);
    checkOutput("noise_run", {31'd0, bus.cpu_run}, 32'd1);

    $display("[TB] framing error");
    applyStimulus(8'hA5, 1'b1, 0);
    applyStimulus(8'h02, 1'b1, 0);
    applyStimulus(8'h11, 1'b1, 0);
    applyStimulus(8'h22, 1'b0, 0);
    repeat (LAT + 10) @(negedge clk);
    checkOutput("fe_err", {31'd0, bus.err}, 32'd1);
    checkOutput("fe_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("fe_run", {31'd0, bus.cpu_run}, 32'd0);
    check_writes("fe_writes");
    tx_q = '{8'hA5, 8'h01, 8'h05, 8'h05};
    send_frame(0);
    checkOutput("fe_recover_err", {31'd0, bus.err}, 32'd0);
    checkOutput("fe_recover_run", {31'd0, bus.cpu_run}, 32'd1);
    check_writes("fe_recover_writes");

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5, 1'b1, 0);
    applyStimulus(8'h02, 1'b1, 0);
    applyStimulus(8'h33, 1'b1, 0);
    b = 8'h44;
    bus.rx = 1'b0;
    repeat (C) @(negedge clk);
    bus.rx = b[0];
    repeat (C) @(negedge clk);
    bus.rx = b[1];
    @(negedge clk);
    checkOutput("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("pre_rst_load_mode", {31'd0, bus.load_mode}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_async_outputs",
                {16'd0, bus.load_mode, bus.load_addr, bus.load_data, bus.cpu_run, bus.busy, bus.done, bus.err},
                32'd0);
    model_reset();
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3 * C) @(negedge clk);
    d0 = dut_done_total;
    tx_q = '{8'hA5, 8'h01, 8'h5A, 8'h5A};
    send_frame(0);
    lit_wr = '{12'h05A};
    pin_writes("post_rst");
    check_writes("post_rst_writes");
    checkOutput("post_rst_run", {31'd0, bus.cpu_run}, 32'd1);
    checkOutput("post_rst_done_pulses", dut_done_total - d0, 32'd1);

    $display("[TB] random frames");
    for (int f = 0; f < 30; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
        applyStimulus(b, ($urandom_range(0, 3) != 0), $urandom_range(0, 2 * C));
      end
      kind  = $urandom_range(0, 9);
      n     = $urandom_range(1, 16);
      fe_at = (kind == 1) ? $urandom_range(0, n - 1) : -1;
      gap   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 * C) : 0;
      applyStimulus(8'hA5, 1'b1, gap);
      if (kind == 0) begin
        b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255));
        applyStimulus(b, 1'b1, gap);
      end else begin
        applyStimulus(8'(n), 1'b1, gap);
        sum = 8'd0;
        for (int i = 0; i < n && fe_at != -2; i++) begin
          b   = 8'($urandom_range(0, 255));
          sum = sum + b;
          if (i == fe_at) begin
            applyStimulus(b, 1'b0, gap);
            fe_at = -2;
          end else begin
            applyStimulus(b, 1'b1, gap);
          end
        end
        if (fe_at != -2) begin
          if (kind == 2) sum = sum + 8'($urandom_range(1, 255));
          applyStimulus(sum, 1'b1, gap);
        end
      end
      repeat (LAT + 10) @(negedge clk);
      check_writes("rand_writes");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
